// File: rtl/cache_line_xfer_pkg.sv
// Shared widths, request encodings, FSM states and the latched-request payload
// for the cache line transfer engine.
package cache_line_xfer_pkg;

  localparam int unsigned BUS_64     = 64;
  localparam int unsigned LINE_W     = 512;
  localparam int unsigned BEAT_W     = 64;
  localparam int unsigned BEAT_N     = 8;
  localparam int unsigned BEAT_IDX_W = 3;
  localparam int unsigned LINE_OFF_W = 6;
  localparam int unsigned TAG_W      = BUS_64 - LINE_OFF_W;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]  line;
    logic              op;
    logic [LINE_W-1:0] wdata;
  } line_req_t;

  // Byte address of one 8-byte beat inside a 64-byte line.
  function automatic logic [BUS_64-1:0] beat_addr(input logic [TAG_W-1:0]      line,
                                                   input logic [BEAT_IDX_W-1:0] beat);
    return {line, beat, 3'b000};
  endfunction

endpackage

// File: rtl/cache_line_xfer.sv
// Serialises one 512-bit cache line request into eight 64-bit memory beats and
// reassembles reads. Optional per-beat watchdog: define CACHE_LINE_XFER_TIMEOUT_EN.
module cache_line_xfer
  import cache_line_xfer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cache_req,
  input  logic [63:0]   i_cache_addr,
  input  logic          i_cache_op,
  input  logic [511:0]  i_cache_wdata,
  output logic          o_cache_ack,
  output logic [511:0]  o_cache_rdata,
  output logic          o_cache_err,
  output logic          o_mem_valid,
  input  logic          i_mem_ready,
  output logic          o_mem_op,
  output logic [63:0]   o_mem_addr,
  output logic [63:0]   o_mem_wdata,
  input  logic          i_mem_resp,
  input  logic [63:0]   i_mem_rdata
);

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEAT_N - 1);

  state_t                r_state, w_state_nxt;
  logic [BEAT_IDX_W-1:0] r_beat, w_beat_nxt;
  logic [BEAT_IDX_W-1:0] w_beat_inc;
  line_req_t             r_req, w_req_nxt;
  logic                  r_ack, w_ack_nxt;
  logic                  r_err, w_err_nxt;
  logic [LINE_W-1:0]     r_rdata, w_rdata_nxt;
  logic                  r_mem_valid, w_mem_valid_nxt;
  logic                  r_mem_op, w_mem_op_nxt;
  logic [BUS_64-1:0]     r_mem_addr, w_mem_addr_nxt;
  logic [BEAT_W-1:0]     r_mem_wdata, w_mem_wdata_nxt;
  logic                  w_is_read;
  logic                  w_timeout_c;
  logic                  w_unused_c;

  assign w_beat_inc = r_beat + BEAT_IDX_W'(1);
  assign w_is_read  = (r_req.op != REQ_WRITE);

`ifdef CACHE_LINE_XFER_TIMEOUT_EN
  localparam int unsigned WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [WDOG_W-1:0] r_wdog;

  // Per-beat watchdog: restarts on each ISSUE entry, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (w_state_nxt == ST_ISSUE && r_state != ST_ISSUE) begin
      r_wdog <= '0;
    end else if ((r_state == ST_ISSUE || r_state == ST_WAIT) && !w_timeout_c) begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  assign w_timeout_c = (r_wdog == WDOG_W'(TIMEOUT));
  assign w_unused_c  = ^i_cache_addr[LINE_OFF_W-1:0];
`else
  assign w_timeout_c = 1'b0;
  assign w_unused_c  = ^{i_cache_addr[LINE_OFF_W-1:0], TIMEOUT != 0};
`endif

  // Next-state and next-output logic; every output leaves through a flop.
  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_req_nxt       = r_req;
    w_ack_nxt       = 1'b0;
    w_err_nxt       = r_err;
    w_rdata_nxt     = r_rdata;
    w_mem_valid_nxt = r_mem_valid;
    w_mem_op_nxt    = r_mem_op;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    unique case (r_state)
      ST_IDLE: begin
        if (i_cache_req) begin
          w_req_nxt.line  = i_cache_addr[BUS_64-1:LINE_OFF_W];
          w_req_nxt.op    = i_cache_op;
          w_req_nxt.wdata = i_cache_wdata;
          w_beat_nxt      = '0;
          w_err_nxt       = 1'b0;
          if (i_cache_op == REQ_READ) w_rdata_nxt = '0;
          w_mem_valid_nxt = 1'b1;
          w_mem_op_nxt    = i_cache_op;
          w_mem_addr_nxt  = beat_addr(i_cache_addr[BUS_64-1:LINE_OFF_W], '0);
          w_mem_wdata_nxt = i_cache_wdata[BEAT_W-1:0];
          w_state_nxt     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_mem_ready) begin
          w_mem_valid_nxt = 1'b0;
          w_state_nxt     = ST_WAIT;
        end else if (w_timeout_c) begin
          w_mem_valid_nxt = 1'b0;
          w_ack_nxt       = 1'b1;
          w_err_nxt       = 1'b1;
          w_state_nxt     = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (i_mem_resp) begin
          if (w_is_read) w_rdata_nxt[{r_beat, 6'd0} +: BEAT_W] = i_mem_rdata;
          if (r_beat == LAST_BEAT) begin
            w_ack_nxt   = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_beat_nxt      = w_beat_inc;
            w_mem_valid_nxt = 1'b1;
            w_mem_addr_nxt  = beat_addr(r_req.line, w_beat_inc);
            w_mem_wdata_nxt = r_req.wdata[{w_beat_inc, 6'd0} +: BEAT_W];
            w_state_nxt     = ST_ISSUE;
          end
        end else if (w_timeout_c) begin
          w_ack_nxt   = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_req       <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_op    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_req       <= w_req_nxt;
      r_ack       <= w_ack_nxt;
      r_err       <= w_err_nxt;
      r_rdata     <= w_rdata_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_mem_op    <= w_mem_op_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign o_cache_ack   = r_ack;
  assign o_cache_err   = r_err;
  assign o_cache_rdata = r_rdata;
  assign o_mem_valid   = r_mem_valid;
  assign o_mem_op      = r_mem_op;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;

endmodule
